instr_encoder: RTL and testbench

- Sequential instruction encoder/loader, the inverse of the CPU decode stage.
- Accepts instruction fields (opcode, register numbers, immediate, jump/branch offset) over a valid/ready handshake and packs them into 32-bit words {OPCODE, DEST, SRC1, SRC2}.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory through a busywait-style write port.
- Used to load programs into the processor and to cross-check the decoder in self-checking benches.

---
 rtl/cpu_isa_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode values (matching the decoder), the
// 32-bit word field positions, encoder FSM states and an opcode legality check.
package cpu_isa_pkg;

    localparam logic [7:0] LOADI = 8'd0;
    localparam logic [7:0] MOV   = 8'd1;
    localparam logic [7:0] ADD   = 8'd2;
    localparam logic [7:0] SUB   = 8'd3;
    localparam logic [7:0] AND   = 8'd4;
    localparam logic [7:0] OR    = 8'd5;
    localparam logic [7:0] J     = 8'd6;
    localparam logic [7:0] BEQ   = 8'd7;
    localparam logic [7:0] BNE   = 8'd11;
    localparam logic [7:0] SRL   = 8'd12;
    localparam logic [7:0] SLL   = 8'd13;
    localparam logic [7:0] SRA   = 8'd14;
    localparam logic [7:0] ROR   = 8'd15;
    localparam logic [7:0] LWD   = 8'd16;
    localparam logic [7:0] LWI   = 8'd17;
    localparam logic [7:0] SWD   = 8'd18;
    localparam logic [7:0] SWI   = 8'd19;

    localparam int OPC_MSB  = 31;
    localparam int DST_MSB  = 23;
    localparam int SRC1_MSB = 15;
    localparam int SRC2_MSB = 7;

    typedef enum logic {
        IDLE,
        WRITE
    } enc_state_e;

    // 8, 9 and 10 are holes in the opcode map; everything above SWI is unused.
    function automatic logic is_legal_opcode(input logic [7:0] op);
        return (op <= BEQ) || ((op >= BNE) && (op <= SWI));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry.
// Ports: CLK, RESET (sync, active-high), push_i/wdata_i, pop_i/rdata_o,
//        full_o, empty_o. DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into {opcode,dest,src1,src2} words, buffers them
// and writes them in order to instruction memory over a busywait port.
// Ports: CLK, RESET (sync, active-high); IN_VALID/IN_READY + field inputs;
//        FLUSH/DONE drain handshake; MEM_* write port; ILLEGAL, ERR_COUNT,
//        WORDS_WRITTEN, ADDR_WRAP status.
module instr_encoder
    import cpu_isa_pkg::*;
#(
    parameter int            FIFO_DEPTH = 4,
    parameter int            AW         = 8,
    parameter logic [AW-1:0] BASE_ADDR  = '0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [7:0]    OPCODE,
    input  logic [2:0]    RD,
    input  logic [2:0]    RS1,
    input  logic [2:0]    RS2,
    input  logic [7:0]    IMM,
    input  logic [7:0]    OFFSET,
    input  logic          FLUSH,
    output logic          MEM_WRITE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [31:0]   MEM_WRITEDATA,
    input  logic          MEM_BUSYWAIT,
    output logic          ILLEGAL,
    output logic [7:0]    ERR_COUNT,
    output logic [AW:0]   WORDS_WRITTEN,
    output logic          ADDR_WRAP,
    output logic          DONE
);

    enc_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [AW:0]   words_q, words_d;
    logic          wrap_q, wrap_d;
    logic          illegal_q, illegal_d;
    logic [7:0]    err_q, err_d;
    logic          done_q, done_d;

    logic          accept, legal, push, pop, complete;
    logic          fifo_full, fifo_empty;
    logic [31:0]   word, fifo_rdata;
    logic [7:0]    dst_f, s1_f, s2_f;
    logic [7:0]    rd8, rs1_8, rs2_8;

    assign rd8   = {5'b0, RD};
    assign rs1_8 = {5'b0, RS1};
    assign rs2_8 = {5'b0, RS2};

    assign IN_READY = !fifo_full;
    assign accept   = IN_VALID && IN_READY;
    assign legal    = is_legal_opcode(OPCODE);
    assign push     = accept && legal;

    always_comb begin
        dst_f = '0;
        s1_f  = '0;
        s2_f  = '0;
        case (OPCODE)
            LOADI, LWI: begin
                dst_f = rd8;
                s2_f  = IMM;
            end
            MOV, LWD: begin
                dst_f = rd8;
                s2_f  = rs2_8;
            end
            ADD, SUB, AND, OR: begin
                dst_f = rd8;
                s1_f  = rs1_8;
                s2_f  = rs2_8;
            end
            J: dst_f = OFFSET;
            BEQ, BNE: begin
                dst_f = OFFSET;
                s1_f  = rs1_8;
                s2_f  = rs2_8;
            end
            SRL, SLL, SRA, ROR: begin
                dst_f = rd8;
                s1_f  = rs1_8;
                s2_f  = IMM;
            end
            SWD: begin
                s1_f = rs1_8;
                s2_f = rs2_8;
            end
            SWI: begin
                s1_f = rs1_8;
                s2_f = IMM;
            end
            default: ;
        endcase
    end

    always_comb begin
        word                     = '0;
        word[OPC_MSB  -: 8]      = OPCODE;
        word[DST_MSB  -: 8]      = dst_f;
        word[SRC1_MSB -: 8]      = s1_f;
        word[SRC2_MSB -: 8]      = s2_f;
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (push),
        .wdata_i (word),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A completing write can hand straight over to the next word.
    assign complete = (state_q == WRITE) && !MEM_BUSYWAIT;
    assign pop      = !fifo_empty && ((state_q == IDLE) || complete);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        words_d   = words_q;
        wrap_d    = wrap_q;
        illegal_d = accept && !legal;
        err_d     = err_q;
        done_d    = FLUSH && fifo_empty && (state_q == IDLE) && !accept;

        if (illegal_d && (err_q != 8'hFF)) err_d = err_q + 8'd1;

        if (complete) begin
            addr_d  = addr_q + AW'(1);
            words_d = words_q + (AW+1)'(1);
            if (addr_q == '1) wrap_d = 1'b1;
        end

        if (pop) begin
            state_d = WRITE;
            wdata_d = fifo_rdata;
        end else if (complete) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            words_q   <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            words_q   <= words_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign MEM_WRITE     = (state_q == WRITE);
    assign MEM_ADDR      = addr_q;
    assign MEM_WRITEDATA = wdata_q;
    assign WORDS_WRITTEN = words_q;
    assign ADDR_WRAP     = wrap_q;
    assign ILLEGAL       = illegal_q;
    assign ERR_COUNT     = err_q;
    assign DONE          = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized traffic
// checked against a field-table reference model.
module tb_instr_encoder;

    localparam int AW  = 8;
    localparam int AW2 = 2;

    logic        CLK = 1'b0;
    logic        RESET, IN_VALID, FLUSH, MEM_BUSYWAIT;
    logic [7:0]  OPCODE, IMM, OFFSET;
    logic [2:0]  RD, RS1, RS2;

    logic          in_ready, mem_write, illegal, addr_wrap, done;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [7:0]    err_count;
    logic [AW:0]   words;

    logic           w_in_ready, w_mem_write, w_illegal, w_addr_wrap, w_done;
    logic [AW2-1:0] w_mem_addr;
    logic [31:0]    w_mem_wdata;
    logic [7:0]     w_err_count;
    logic [AW2:0]   w_words;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    instr_encoder #(.FIFO_DEPTH(4), .AW(AW), .BASE_ADDR(8'd0)) u_dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_ready),
        .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2), .IMM(IMM),
        .OFFSET(OFFSET), .FLUSH(FLUSH), .MEM_WRITE(mem_write),
        .MEM_ADDR(mem_addr), .MEM_WRITEDATA(mem_wdata),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .ILLEGAL(illegal),
        .ERR_COUNT(err_count), .WORDS_WRITTEN(words),
        .ADDR_WRAP(addr_wrap), .DONE(done)
    );

    instr_encoder #(.FIFO_DEPTH(4), .AW(AW2), .BASE_ADDR(2'd0)) u_wrap (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(w_in_ready),
        .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2), .IMM(IMM),
        .OFFSET(OFFSET), .FLUSH(FLUSH), .MEM_WRITE(w_mem_write),
        .MEM_ADDR(w_mem_addr), .MEM_WRITEDATA(w_mem_wdata),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .ILLEGAL(w_illegal),
        .ERR_COUNT(w_err_count), .WORDS_WRITTEN(w_words),
        .ADDR_WRAP(w_addr_wrap), .DONE(w_done)
    );

    // Completed writes of each instance, captured half a cycle before the edge.
    logic [31:0] rec_data[$];
    int          rec_addr[$];
    logic [31:0] wrec_data[$];
    int          wrec_addr[$];
    int          wr_cycles = 0;
    int          wr_runs   = 0;
    logic        prev_w    = 1'b0;

    always @(negedge CLK) begin
        if (!RESET && !MEM_BUSYWAIT) begin
            if (mem_write) begin
                rec_data.push_back(mem_wdata);
                rec_addr.push_back(int'(mem_addr));
            end
            if (w_mem_write) begin
                wrec_data.push_back(w_mem_wdata);
                wrec_addr.push_back(int'(w_mem_addr));
            end
        end
        if (mem_write) wr_cycles <= wr_cycles + 1;
        if (mem_write && !prev_w) wr_runs <= wr_runs + 1;
        prev_w <= mem_write;
    end

    function automatic bit ref_legal(input logic [7:0] op);
        return (op inside {[8'd0:8'd7], [8'd11:8'd19]});
    endfunction

    function automatic logic [31:0] ref_pack(
        input logic [7:0] op, input logic [2:0] rd, input logic [2:0] a,
        input logic [2:0] b, input logic [7:0] imm, input logic [7:0] off);
        logic [7:0] d8 = {5'b0, rd};
        logic [7:0] a8 = {5'b0, a};
        logic [7:0] b8 = {5'b0, b};
        case (op)
            8'd0, 8'd17:                return {op, d8, 8'h00, imm};
            8'd1, 8'd16:                return {op, d8, 8'h00, b8};
            8'd2, 8'd3, 8'd4, 8'd5:     return {op, d8, a8, b8};
            8'd6:                       return {op, off, 16'h0000};
            8'd7, 8'd11:                return {op, off, a8, b8};
            8'd12, 8'd13, 8'd14, 8'd15: return {op, d8, a8, imm};
            8'd18:                      return {op, 8'h00, a8, b8};
            8'd19:                      return {op, 8'h00, a8, imm};
            default:                    return 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        RESET    = 1'b1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic push(input logic [7:0] op, input logic [2:0] rd,
                        input logic [2:0] a, input logic [2:0] b,
                        input logic [7:0] imm, input logic [7:0] off,
                        input bit rand_bw);
        int waited = 0;
        OPCODE = op; RD = rd; RS1 = a; RS2 = b; IMM = imm; OFFSET = off;
        IN_VALID = 1'b1;
        while (!in_ready && waited < 300) begin
            @(posedge CLK); #1;
            waited++;
            if (rand_bw) MEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: IN_READY=%0b, required 1", in_ready);
            IN_VALID = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        if (rand_bw) MEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int c = 0;
        while (rec_data.size() < target && c < 2000) begin
            @(posedge CLK); #1;
            c++;
        end
        if (rec_data.size() < target) begin
            n_tests++; n_fail++;
            $display("FAIL write_timeout: got %0d writes, required %0d",
                     rec_data.size(), target);
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        int base;
        do_reset();
        n_tests++;
        if ({mem_write, illegal, done, addr_wrap, in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_flags: W/I/D/WRAP/RDY=%b, required 00001",
                     {mem_write, illegal, done, addr_wrap, in_ready});
        end
        n_tests++;
        if (mem_addr !== 8'd0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem: addr=%0d data=%h, required 0/0",
                     mem_addr, mem_wdata);
        end
        n_tests++;
        if (err_count !== 8'd0 || words !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: err=%0d words=%0d, required 0/0",
                     err_count, words);
        end
        MEM_BUSYWAIT = 1'b1;
        push(8'd2, 3'd1, 3'd2, 3'd3, 8'h00, 8'h00, 1'b0);
        push(8'd9, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0);
        push(8'd0, 3'd5, 3'd0, 3'd0, 8'h77, 8'h00, 1'b0);
        push(8'd3, 3'd4, 3'd5, 3'd6, 8'h00, 8'h00, 1'b0);
        base = rec_data.size();
        do_reset();
        n_tests++;
        if (mem_write !== 1'b0 || mem_addr !== 8'd0 || in_ready !== 1'b1 ||
            err_count !== 8'd0 || words !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: W=%b addr=%0d rdy=%b err=%0d words=%0d, required 0/0/1/0/0",
                     mem_write, mem_addr, in_ready, err_count, words);
        end
        MEM_BUSYWAIT = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        n_tests++;
        if (rec_data.size() != base || mem_write !== 1'b0 || words !== '0) begin
            n_fail++;
            $display("FAIL reset_stale: writes=%0d W=%b words=%0d, required 0/0/0",
                     rec_data.size() - base, mem_write, words);
        end
    endtask

    task automatic test_add_latency();
        do_reset();
        MEM_BUSYWAIT = 1'b0;
        push(8'd2, 3'd3, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0);
        n_tests++;
        if (mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL add_early: MEM_WRITE=%b after accept edge, required 0", mem_write);
        end
        @(posedge CLK); #1;
        n_tests++;
        if (mem_write !== 1'b1 || mem_wdata !== 32'h02030102 || mem_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL add_write: W=%b data=%h addr=%0d, required 1/02030102/0",
                     mem_write, mem_wdata, mem_addr);
        end
        @(posedge CLK); #1;
        n_tests++;
        if (mem_write !== 1'b0 || words !== 9'd1 || mem_addr !== 8'd1) begin
            n_fail++;
            $display("FAIL add_after: W=%b words=%0d addr=%0d, required 0/1/1",
                     mem_write, words, mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        int base, cyc0, run0;
        logic [31:0] exp_d[3];
        exp_d[0] = 32'h000400FF;
        exp_d[1] = 32'h06FE0000;
        exp_d[2] = 32'h13000210;
        do_reset();
        MEM_BUSYWAIT = 1'b0;
        base = rec_data.size();
        cyc0 = wr_cycles;
        run0 = wr_runs;
        push(8'd0,  3'd4, 3'd0, 3'd0, 8'hFF, 8'h00, 1'b0);
        push(8'd6,  3'd0, 3'd0, 3'd0, 8'h00, 8'hFE, 1'b0);
        push(8'd19, 3'd0, 3'd2, 3'd0, 8'h10, 8'h00, 1'b0);
        wait_writes(base + 3);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rec_data[base+i] !== exp_d[i] || rec_addr[base+i] != i) begin
                n_fail++;
                $display("FAIL b2b_word%0d: %h@%0d, required %h@%0d",
                         i, rec_data[base+i], rec_addr[base+i], exp_d[i], i);
            end
        end
        n_tests++;
        if (wr_cycles - cyc0 != 3 || wr_runs - run0 != 1) begin
            n_fail++;
            $display("FAIL b2b_contig: high cycles=%0d runs=%0d, required 3/1",
                     wr_cycles - cyc0, wr_runs - run0);
        end
    endtask

    task automatic test_illegal();
        int base;
        do_reset();
        MEM_BUSYWAIT = 1'b0;
        base = rec_data.size();
        push(8'd8, 3'd1, 3'd1, 3'd1, 8'h11, 8'h22, 1'b0);
        n_tests++;
        if (illegal !== 1'b1 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_pulse: ILLEGAL=%b err=%0d, required 1/1",
                     illegal, err_count);
        end
        push(8'd3, 3'd1, 3'd2, 3'd3, 8'h00, 8'h00, 1'b0);
        n_tests++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_width: ILLEGAL=%b second cycle, required 0", illegal);
        end
        wait_writes(base + 1);
        repeat (3) @(posedge CLK);
        #1;
        n_tests++;
        if (rec_data.size() != base + 1 || rec_data[base] !== 32'h03010203 ||
            rec_addr[base] != 0 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_drop: writes=%0d first=%h@%0d err=%0d, required 1/03010203@0/1",
                     rec_data.size() - base, rec_data[base], rec_addr[base], err_count);
        end
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 255; i++)
            push(8'($urandom_range(20, 255)), 3'd0, 3'd0, 3'd0, 8'h0, 8'h0, 1'b0);
        n_tests++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL err_255: ERR_COUNT=%0d, required 255", err_count);
        end
        push(8'd10, 3'd0, 3'd0, 3'd0, 8'h0, 8'h0, 1'b0);
        n_tests++;
        if (err_count !== 8'd255 || illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sat: ERR_COUNT=%0d ILLEGAL=%b, required 255/1",
                     err_count, illegal);
        end
    endtask

    task automatic test_backpressure();
        int base;
        bit ok = 1'b1;
        logic [31:0] exp_d[6];
        logic [2:0]  r;
        do_reset();
        base = rec_data.size();
        MEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r = 3'(i);
            exp_d[i] = ref_pack(8'd4, r, 3'd7 - r, r, 8'h00, 8'h00);
            push(8'd4, r, 3'd7 - r, r, 8'h00, 8'h00, 1'b0);
        end
        exp_d[5] = ref_pack(8'd18, 3'd0, 3'd6, 3'd5, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0) ok = 1'b0;
            @(posedge CLK); #1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_ready: IN_READY seen 1 with full FIFO, required 0");
        end
        MEM_BUSYWAIT = 1'b0;
        push(8'd18, 3'd0, 3'd6, 3'd5, 8'h00, 8'h00, 1'b0);
        wait_writes(base + 6);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (rec_data[base+i] !== exp_d[i] || rec_addr[base+i] != i) begin
                n_fail++;
                $display("FAIL bp_word%0d: %h@%0d, required %h@%0d",
                         i, rec_data[base+i], rec_addr[base+i], exp_d[i], i);
            end
        end
        n_tests++;
        if (words !== 9'd6) begin
            n_fail++;
            $display("FAIL bp_count: WORDS_WRITTEN=%0d, required 6", words);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        int          exp_err = 0;
        int          base, bad = 0;
        logic [7:0]  legal_ops[17] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
                                       8'd6, 8'd7, 8'd11, 8'd12, 8'd13,
                                       8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};
        logic [7:0]  op, imm, off;
        logic [2:0]  rd, a, b;
        do_reset();
        base = rec_data.size();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                op = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8, 10))
                                                 : 8'($urandom_range(20, 255));
            else
                op = legal_ops[$urandom_range(0, 16)];
            rd  = 3'($urandom_range(0, 7));
            a   = 3'($urandom_range(0, 7));
            b   = 3'($urandom_range(0, 7));
            imm = 8'($urandom_range(0, 255));
            off = 8'($urandom_range(0, 255));
            if (ref_legal(op)) exp_q.push_back(ref_pack(op, rd, a, b, imm, off));
            else exp_err++;
            push(op, rd, a, b, imm, off, 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge CLK); #1;
            end
        end
        MEM_BUSYWAIT = 1'b0;
        wait_writes(base + exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= rec_data.size() || rec_data[base+i] !== exp_q[i] ||
                rec_addr[base+i] != i) begin
                if (bad < 4)
                    $display("FAIL rnd_word%0d: %h, required %h@%0d",
                             i, (base + i < rec_data.size()) ? rec_data[base+i] : 32'hx,
                             exp_q[i], i);
                bad++;
            end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rnd_stream: %0d bad words of %0d, required 0", bad, exp_q.size());
        end
        n_tests++;
        if (err_count !== 8'(exp_err) || int'(words) != exp_q.size() ||
            rec_data.size() - base != exp_q.size()) begin
            n_fail++;
            $display("FAIL rnd_counts: err=%0d words=%0d writes=%0d, required %0d/%0d/%0d",
                     err_count, words, rec_data.size() - base,
                     exp_err, exp_q.size(), exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int          base;
        bit          s3 = 0, s4 = 0, s5 = 0, chk_next = 0, done_ok = 0;
        logic [31:0] exp_d[5];
        int          exp_a[5] = '{0, 1, 2, 3, 0};
        do_reset();
        MEM_BUSYWAIT = 1'b0;
        FLUSH = 1'b1;
        base = wrec_data.size();
        for (int i = 0; i < 5; i++) begin
            exp_d[i] = ref_pack(8'd12, 3'(i), 3'(i + 1), 3'd0, 8'(8'h40 + i), 8'h00);
            push(8'd12, 3'(i), 3'(i + 1), 3'd0, 8'(8'h40 + i), 8'h00, 1'b0);
        end
        for (int c = 0; c < 30; c++) begin
            if (chk_next) begin
                chk_next = 0;
                done_ok  = 1;
                n_tests++;
                if (w_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_done_rise: DONE=%b, required 1", w_done);
                end
            end
            if (w_words == 3'd3 && !s3) begin
                s3 = 1;
                n_tests++;
                if (w_addr_wrap !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_early: ADDR_WRAP=%b after 3 writes, required 0", w_addr_wrap);
                end
            end
            if (w_words == 3'd4 && !s4) begin
                s4 = 1;
                n_tests++;
                if (w_addr_wrap !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_set: ADDR_WRAP=%b after 4 writes, required 1", w_addr_wrap);
                end
            end
            if (w_words == 3'd5 && !s5) begin
                s5 = 1;
                chk_next = 1;
                n_tests++;
                if (w_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_done_early: DONE=%b at last write, required 0", w_done);
                end
            end
            @(posedge CLK); #1;
        end
        n_tests++;
        if (!(s3 && s4 && s5 && done_ok)) begin
            n_fail++;
            $display("FAIL wrap_progress: seen 3/4/5/done=%b%b%b%b, required 1111",
                     s3, s4, s5, done_ok);
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (base + i >= wrec_data.size() || wrec_data[base+i] !== exp_d[i] ||
                wrec_addr[base+i] != exp_a[i]) begin
                n_fail++;
                $display("FAIL wrap_word%0d: addr=%0d, required %h@%0d", i,
                         (base + i < wrec_addr.size()) ? wrec_addr[base+i] : -1,
                         exp_d[i], exp_a[i]);
            end
        end
        FLUSH = 1'b0;
        @(posedge CLK); #1;
        n_tests++;
        if (w_done !== 1'b0 || w_addr_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_flush_drop: DONE=%b WRAP=%b, required 0/1", w_done, w_addr_wrap);
        end
    endtask

    initial begin
        RESET = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0; MEM_BUSYWAIT = 1'b0;
        OPCODE = '0; RD = '0; RS1 = '0; RS2 = '0; IMM = '0; OFFSET = '0;
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_illegal();
        test_err_saturate();
        test_backpressure();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
